// File: rtl/rps_pkg.sv
// Shared move/mode encodings, referee state type and BCD score helpers.
package rps_pkg;

   localparam logic [1:0] ROCK    = 2'b00;
   localparam logic [1:0] SCISSOR = 2'b01;
   localparam logic [1:0] PAPER   = 2'b10;
   localparam logic [1:0] INVALID = 2'b11;

   localparam logic [1:0] MODE_RANDOM    = 2'b00;
   localparam logic [1:0] MODE_MARKOV    = 2'b01;
   localparam logic [1:0] MODE_REINFORCE = 2'b10;
   localparam logic [1:0] MODE_RESERVED  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StWaitReady,
      StJudge,
      StShow
   } referee_state_e;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_sat_inc(input logic [7:0] score);
      logic [7:0] result;
      if (score == 8'h99) begin
         result = 8'h99;
      end else if (score[3:0] == 4'd9) begin
         result = {score[7:4] + 4'd1, 4'd0};
      end else begin
         result = {score[7:4], score[3:0] + 4'd1};
      end
      return result;
   endfunction

   // True when move a beats move b (both assumed valid).
   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return ((a == ROCK)    && (b == SCISSOR)) ||
             ((a == SCISSOR) && (b == PAPER))   ||
             ((a == PAPER)   && (b == ROCK));
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces the active-low start button; emits press/release pulses.
module key_debouncer
   import rps_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic start_n,
   output logic key_press,
   output logic key_release,
   output logic key_up
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             sync_prev;
   logic [CNT_W-1:0] stable_cnt;
   // Cleared by reset so a button held through reset must be released before it can press.
   logic             armed;

   // Synchroniser, stability counter and debounced level with edge pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_a      <= 1'b1;
         sync_b      <= 1'b1;
         sync_prev   <= 1'b1;
         stable_cnt  <= '0;
         key_up      <= 1'b1;
         armed       <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         sync_a      <= start_n;
         sync_b      <= sync_a;
         sync_prev   <= sync_b;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         if (sync_b != sync_prev) begin
            stable_cnt <= '0;
         end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + 1'b1;
         end else begin
            if (sync_b != key_up) begin
               key_up      <= sync_b;
               key_press   <= armed & ~sync_b;
               key_release <= sync_b;
            end
            if (sync_b) begin
               armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/round_referee.sv
// Rock-paper-scissors round referee: latches moves on a press, judges, keeps BCD scores.
module round_referee
   import rps_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_n,
   input  logic [1:0] user_choice,
   input  logic [1:0] com_choice,
   input  logic       com_ready,
   input  logic [1:0] mode,
   output logic [1:0] com_loaded,
   output logic [1:0] user_loaded,
   output logic       uwin,
   output logic       cwin,
   output logic       equ,
   output logic [7:0] user_score,
   output logic [7:0] com_score,
   output logic       round_done,
   output logic       err,
   output logic       busy
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

   referee_state_e   state;
   logic [TMO_W-1:0] wait_cnt;
   logic [1:0]       user_latch;
   logic [1:0]       com_latch;
   logic [1:0]       com_judged;
   logic             key_press;
   logic             key_release;
   logic             key_up;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clock      (clock),
      .reset      (reset),
      .start_n    (start_n),
      .key_press  (key_press),
      .key_release(key_release),
      .key_up     (key_up)
   );

   // An invalid computer move is scored as rock.
   assign com_judged = (com_latch == INVALID) ? ROCK : com_latch;
   assign busy       = (state != StIdle);

   // Round FSM with registered flags, scores and pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= StIdle;
         wait_cnt    <= '0;
         user_latch  <= ROCK;
         com_latch   <= ROCK;
         user_loaded <= ROCK;
         com_loaded  <= ROCK;
         uwin        <= 1'b0;
         cwin        <= 1'b0;
         equ         <= 1'b0;
         user_score  <= 8'h00;
         com_score   <= 8'h00;
         round_done  <= 1'b0;
         err         <= 1'b0;
      end else begin
         round_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            StIdle: begin
               if (key_press) begin
                  user_latch <= user_choice;
                  if (user_choice == INVALID) begin
                     err <= 1'b1;
                  end else if ((mode == MODE_REINFORCE) && !com_ready) begin
                     wait_cnt <= '0;
                     state    <= StWaitReady;
                  end else begin
                     com_latch <= com_choice;
                     state     <= StJudge;
                  end
               end
            end
            StWaitReady: begin
               if (com_ready) begin
                  com_latch <= com_choice;
                  state     <= StJudge;
               end else if (wait_cnt == TMO_MAX) begin
                  err   <= 1'b1;
                  state <= StIdle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StJudge: begin
               // Visible outputs change only here, so they always describe a judged round.
               user_loaded <= user_latch;
               com_loaded  <= com_latch;
               equ         <= (user_latch == com_judged);
               uwin        <= beats(user_latch, com_judged);
               cwin        <= (user_latch != com_judged) && !beats(user_latch, com_judged);
               if (beats(user_latch, com_judged)) begin
                  user_score <= bcd_sat_inc(user_score);
               end else if (user_latch != com_judged) begin
                  com_score <= bcd_sat_inc(com_score);
               end
               round_done <= 1'b1;
               state      <= StShow;
            end
            StShow: begin
               // Level check also catches a release that landed while still waiting.
               if (key_release || key_up) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_round_referee.sv
// Self-checking bench for round_referee with a score/outcome model kept in plain integers.
module tb_round_referee;

   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_n;
   logic [1:0] user_choice;
   logic [1:0] com_choice;
   logic       com_ready;
   logic [1:0] mode;
   logic [1:0] com_loaded;
   logic [1:0] user_loaded;
   logic       uwin;
   logic       cwin;
   logic       equ;
   logic [7:0] user_score;
   logic [7:0] com_score;
   logic       round_done;
   logic       err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int exp_us, exp_cs;
   int exp_uwin, exp_cwin, exp_equ;
   int exp_ul, exp_cl;

   always #5 clock = ~clock;

   round_referee #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start_n    (start_n),
      .user_choice(user_choice),
      .com_choice (com_choice),
      .com_ready  (com_ready),
      .mode       (mode),
      .com_loaded (com_loaded),
      .user_loaded(user_loaded),
      .uwin       (uwin),
      .cwin       (cwin),
      .equ        (equ),
      .user_score (user_score),
      .com_score  (com_score),
      .round_done (round_done),
      .err        (err),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic model_reset();
      exp_us = 0; exp_cs = 0;
      exp_uwin = 0; exp_cwin = 0; exp_equ = 0;
      exp_ul = 0; exp_cl = 0;
   endtask

   // rock=0 beats scissor=1 beats paper=2 beats rock: the winner's code is one below, mod 3.
   task automatic model_round(input int u, input int c);
      int ce;
      ce = (c == 3) ? 0 : c;
      exp_uwin = 0; exp_cwin = 0; exp_equ = 0;
      if (u == ce) begin
         exp_equ = 1;
      end else if (ce == (u + 1) % 3) begin
         exp_uwin = 1;
         if (exp_us < 99) exp_us++;
      end else begin
         exp_cwin = 1;
         if (exp_cs < 99) exp_cs++;
      end
      exp_ul = u; exp_cl = c;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " uwin"}, 32'(uwin), 32'(exp_uwin));
      check({tag, " cwin"}, 32'(cwin), 32'(exp_cwin));
      check({tag, " equ"}, 32'(equ), 32'(exp_equ));
      check({tag, " user_score"}, 32'(user_score), 32'(to_bcd(exp_us)));
      check({tag, " com_score"}, 32'(com_score), 32'(to_bcd(exp_cs)));
   endtask

   task automatic check_loaded(input string tag);
      check({tag, " user_loaded"}, 32'(user_loaded), 32'(exp_ul));
      check({tag, " com_loaded"}, 32'(com_loaded), 32'(exp_cl));
   endtask

   task automatic release_and_settle(input string tag);
      int n;
      start_n = 1'b1;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check({tag, " back idle"}, 32'(busy), 32'd0);
      tick(DEB + 6);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      model_reset();
   endtask

   // One full non-waiting round: press, judge, compare, release.
   task automatic play(input int u, input int c, input int m, input logic rdy, input string tag);
      int n, busy_at, done_at;
      user_choice = 2'(u); com_choice = 2'(c); mode = 2'(m); com_ready = rdy;
      start_n = 1'b0;
      n = 0; busy_at = -1; done_at = -1;
      while (done_at < 0 && n < 60) begin
         @(negedge clock);
         n++;
         if (busy === 1'b1 && busy_at < 0) busy_at = n;
         if (round_done === 1'b1) done_at = n;
      end
      check({tag, " round_done seen"}, 32'(done_at >= 0), 32'd1);
      check({tag, " judge-to-done latency"}, 32'(done_at - busy_at), 32'd1);
      model_round(u, c);
      check_outputs(tag);
      check_loaded(tag);
      @(negedge clock);
      check({tag, " single pulse"}, 32'(round_done), 32'd0);
      check({tag, " busy in show"}, 32'(busy), 32'd1);
      com_ready = 1'b0;
      release_and_settle(tag);
   endtask

   task automatic play_win(input string tag);
      int u, m;
      u = $urandom_range(0, 2);
      m = $urandom_range(0, 3);
      play(u, (u + 1) % 3, m, 1'b1, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n, cnt, u, c, m;
      logic rdy;

      reset = 1'b1; start_n = 1'b1; user_choice = 2'b00; com_choice = 2'b00;
      com_ready = 1'b0; mode = 2'b00;
      tick(2);
      reset = 1'b0;
      model_reset();
      tick(DEB + 6);

      // Reset state
      check_outputs("reset");
      check_loaded("reset");
      check("reset round_done", 32'(round_done), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);

      // Basic round: rock vs scissor
      play(0, 1, 0, 1'b0, "basic");
      check("basic user_score", 32'(user_score), 32'h01);
      check("basic com_score", 32'(com_score), 32'h00);

      // Randomised mixed rounds
      for (int i = 0; i < 24; i++) begin
         u = $urandom_range(0, 2);
         c = $urandom_range(0, 3);
         m = $urandom_range(0, 3);
         rdy = (m == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         play(u, c, m, rdy, "random");
      end

      // BCD carry and saturation
      do_reset();
      tick(DEB + 6);
      for (int i = 0; i < 9; i++) play_win("streak");
      check("bcd 09", 32'(user_score), 32'h09);
      play_win("carry");
      check("bcd carry 10", 32'(user_score), 32'h10);
      while (exp_us < 99) play_win("climb");
      check("bcd 99", 32'(user_score), 32'h99);
      play_win("saturate");
      check("saturated score", 32'(user_score), 32'h99);
      check("saturated uwin", 32'(uwin), 32'd1);

      // Mode 10: com_ready arrives late
      user_choice = 2'b01; com_choice = 2'b00; mode = 2'b10; com_ready = 1'b0;
      start_n = 1'b0;
      n = 0;
      while (busy !== 1'b1 && n < 40) begin @(negedge clock); n++; end
      check("wait entered", 32'(busy), 32'd1);
      tick(5);
      com_choice = 2'b10; com_ready = 1'b1;
      @(negedge clock);
      check("late ready judge cycle", 32'(round_done), 32'd0);
      @(negedge clock);
      check("late ready done", 32'(round_done), 32'd1);
      model_round(1, 2);
      check_outputs("late ready");
      check_loaded("late ready");
      com_ready = 1'b0;
      release_and_settle("late ready");

      // Mode 10: timeout
      user_choice = 2'b00; com_choice = 2'b01; mode = 2'b10; com_ready = 1'b0;
      start_n = 1'b0;
      n = 0;
      while (busy !== 1'b1 && n < 40) begin @(negedge clock); n++; end
      check("timeout wait entered", 32'(busy), 32'd1);
      cnt = 0;
      for (int i = 1; i <= int'(TMO); i++) begin
         @(negedge clock);
         if (i < int'(TMO) && err === 1'b1) cnt++;
      end
      check("timeout no early err", 32'(cnt), 32'd0);
      check("timeout err", 32'(err), 32'd1);
      check("timeout idle", 32'(busy), 32'd0);
      check_outputs("timeout");
      check_loaded("timeout");
      release_and_settle("timeout");

      // Bouncing press, then a glitch while in SHOW
      user_choice = 2'b10; com_choice = 2'b00; mode = 2'b00;
      start_n = 1'b0; tick(1);
      start_n = 1'b1; tick(1);
      start_n = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (round_done === 1'b1) cnt++;
      end
      check("bounce round count", 32'(cnt), 32'd1);
      model_round(2, 0);
      check_outputs("bounce");
      start_n = 1'b1; tick(2);
      start_n = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (round_done === 1'b1) cnt++;
      end
      check("press in show ignored", 32'(cnt), 32'd0);
      check("still in show", 32'(busy), 32'd1);
      check_outputs("show glitch");
      release_and_settle("bounce");

      // Invalid user move
      user_choice = 2'b11; com_choice = 2'b01; mode = 2'b00;
      start_n = 1'b0;
      n = 0;
      while (err !== 1'b1 && n < 40) begin @(negedge clock); n++; end
      check("invalid err", 32'(err), 32'd1);
      check("invalid busy", 32'(busy), 32'd0);
      check_outputs("invalid");
      @(negedge clock);
      check("invalid err pulse", 32'(err), 32'd0);
      release_and_settle("invalid");

      // Reset during SHOW with the button held
      user_choice = 2'b00; com_choice = 2'b10; mode = 2'b01;
      start_n = 1'b0;
      n = 0;
      while (round_done !== 1'b1 && n < 40) begin @(negedge clock); n++; end
      check("pre-reset round", 32'(round_done), 32'd1);
      tick(2);
      do_reset();
      check_outputs("mid reset");
      check_loaded("mid reset");
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset err", 32'(err), 32'd0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (round_done === 1'b1 || busy === 1'b1 || err === 1'b1) cnt++;
      end
      check("held button ignored", 32'(cnt), 32'd0);
      start_n = 1'b1;
      tick(DEB + 8);
      play(0, 2, 0, 1'b0, "after reset");
      check("after reset com_score", 32'(com_score), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
